seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter that produces the bit streams our serial sequence detectors consume. It latches a PAT_W-bit pattern and a repetition count, then shifts the pattern out MSB-first, one bit per clk, for the requested number of repetitions. It sits in front of the detectors as a stimulus/traffic source and as the transmit end of single-bit pattern links. Outputs are fully registered.

Parameters:
PAT_W, 3, pattern width in bits (>=2)
CNT_W, 4, width of repetition count
GAP_LEN, 2, idle bits between repetitions (used only with SEQGEN_GAP_EN; >=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request transmission; sampled only in IDLE
pat  input  PAT_W  pattern, latched on accepted start
reps  input  CNT_W  repetition count, latched on accepted start; 0 = continuous until stop
stop  input  1  request end of continuous/long transmission
out  output  1  serial data; 0 whenever valid=0
valid  output  1  out carries a pattern bit
busy  output  1  transmission in progress
frame_end  output  1  high with bit 0 of every repetition
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset (rst=0, async): state IDLE; out, valid, busy, frame_end, done = 0; internal pattern/count/index regs cleared. Reset mid-stream aborts immediately, with no done pulse.
- States: IDLE, SEND, GAP (only with macro), DONE.
- IDLE: start=1 at edge T -> latch pat, reps; bit index = PAT_W-1; rep counter = reps; go SEND. At T+1: out=pat[PAT_W-1], valid=1, busy=1 (one-cycle latency).
- SEND: each cycle emit pat[idx] and decrement idx. With idx=0: frame_end=1.
  - If last repetition (counter==1, reps!=0) or stop has been seen: go DONE.
  - Otherwise decrement the counter (not when reps==0), reload idx=PAT_W-1, and continue back-to-back with no bubble.
- stop: sampled every cycle in SEND/GAP and held in a sticky flag. The current repetition always completes in full; it is never truncated. stop in IDLE/DONE is ignored. The flag clears on entry to IDLE.
- DONE: single cycle. done=1, busy=0, valid=0, out=0, then IDLE. busy is high from T+1 through the final bit inclusive.
- start while busy: ignored, not queued. start during the DONE cycle: ignored. Earliest restart is the cycle after done.
- Counter arithmetic: CNT_W-bit unsigned. reps=2^CNT_W-1 gives that many repetitions exactly; no wrap.
- reps=0: continuous transmission. frame_end pulses every PAT_W cycles until stop.
- pat/reps changes while busy have no effect.

Optional Feature:
Macro SEQGEN_GAP_EN.
- Defined: between consecutive repetitions (never after the final one), enter GAP for GAP_LEN cycles: valid=0, out=0, busy=1, frame_end=0. Then reload idx and return to SEND. stop seen during GAP ends the gap at once: the next cycle is DONE.
- Undefined: GAP state and its counter are not built, and repetitions are back-to-back. The GAP_LEN parameter is accepted but unused.

Test Plan:
- Reset rst=0 for 15 time units, then start=1 one cycle with pat=101, reps=1 -> out=1,0,1 on cycles 1-3 with valid=1 and busy=1; frame_end on cycle 3; done on cycle 4; all outputs 0 afterwards.
- pat=101, reps=3 -> out 101101101 on cycles 1-9, no bubbles; frame_end on cycles 3, 6, 9; done on cycle 10. Feeding this stream to the 101 detector gives its expected det pulses, including overlaps.
- pat=110, reps=0, stop pulsed on cycle 5 -> 110110 on cycles 1-6 (second repetition completes); done on cycle 7; no cycle-8 transmission.
- start re-asserted on cycles 2 and 4 with pat=011 during a reps=1 transfer of pat=101 -> stream stays 101; done on cycle 4; start on cycle 5 is accepted and 011 appears on cycles 6-8.
- rst driven low in mid-cycle 2 of pat=101, reps=2 -> out, valid, busy drop to 0 immediately (asynchronously); no done; after release, a new start gives a clean 101 from cycle 1.
- With SEQGEN_GAP_EN, GAP_LEN=2, pat=101, reps=2 -> cycles 1-8 show valid=1,1,1,0,0,1,1,1 and out=1,0,1,0,0,1,0,1; busy stays 1 through the gap; done on cycle 9. Without the macro -> 101101 on cycles 1-6, done on cycle 7.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repetition count and stop
// Define SEQGEN_GAP_EN to insert GAP_LEN idle bits between consecutive repetitions.
module seq_pattern_gen #(
  parameter int PAT_W   = 3,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  input  logic             stop,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  if (PAT_W < 2 || CNT_W < 1 || GAP_LEN < 1) begin : g_bad_param
    $error("seq_pattern_gen: invalid parameter values");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
`ifdef SEQGEN_GAP_EN
    ST_GAP,
`endif
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             inf_q;
  logic             stop_q;
  logic             out_q;
  logic             valid_q;
  logic             busy_q;
  logic             frame_end_q;
  logic             done_q;

`ifdef SEQGEN_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gap_q;
`endif

  // A stop arriving in the same cycle as a repetition boundary still counts.
  logic stop_d;
  logic last_rep_d;
  assign stop_d     = stop_q | stop;
  assign last_rep_d = stop_d | (!inf_q && (cnt_q == CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      inf_q       <= 1'b0;
      stop_q      <= 1'b0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQGEN_GAP_EN
      gap_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          stop_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state_q     <= ST_SEND;
            pat_q       <= pat;
            cnt_q       <= reps;
            inf_q       <= (reps == '0);
            idx_q       <= IDX_MSB;
            out_q       <= pat[PAT_W-1];
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            frame_end_q <= 1'b0;
          end
        end
        ST_SEND: begin
          stop_q <= stop_d;
          // idx_q is the index of the bit currently on out.
          if (idx_q != '0) begin
            idx_q       <= idx_q - 1'b1;
            out_q       <= pat_q[idx_q - 1'b1];
            frame_end_q <= (idx_q == IDX_W'(1));
          end else if (last_rep_d) begin
            state_q     <= ST_DONE;
            out_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            if (!inf_q) begin
              cnt_q <= cnt_q - 1'b1;
            end
            frame_end_q <= 1'b0;
`ifdef SEQGEN_GAP_EN
            state_q <= ST_GAP;
            gap_q   <= GAP_LAST;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
`else
            idx_q <= IDX_MSB;
            out_q <= pat_q[PAT_W-1];
`endif
          end
        end
`ifdef SEQGEN_GAP_EN
        ST_GAP: begin
          stop_q <= stop_d;
          if (stop_d) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_q == '0) begin
            state_q <= ST_SEND;
            idx_q   <= IDX_MSB;
            out_q   <= pat_q[PAT_W-1];
            valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_q       <= 1'b0;
          valid_q     <= 1'b0;
          busy_q      <= 1'b0;
          frame_end_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_end = frame_end_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - self-checking bench for seq_pattern_gen against a stream-level model
module tb_seq_pattern_gen;

  localparam int PAT_W   = 3;
  localparam int CNT_W   = 4;
  localparam int GAP_LEN = 2;
`ifdef SEQGEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk   = 1'b1;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic [PAT_W-1:0] pat   = '0;
  logic [CNT_W-1:0] reps  = '0;
  logic             out;
  logic             valid;
  logic             busy;
  logic             frame_end;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Expected {out, valid, busy, frame_end, done} per cycle, cycle 1 first.
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pat      (pat),
    .reps     (reps),
    .stop     (stop),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .frame_end(frame_end),
    .done     (done)
  );

  function automatic logic [4:0] obs();
    return {out, valid, busy, frame_end, done};
  endfunction

  // Whole-transfer stream: repetitions of the pattern, optional gaps, then one done cycle.
  task automatic build_model(input logic [PAT_W-1:0] p, input int r, input int stop_cyc);
    int c = 0;
    int n = 0;
    bit fin = 1'b0;
    exp_q.delete();
    while (!fin && c < 4000) begin
      n++;
      for (int b = PAT_W - 1; b >= 0; b--) begin
        c++;
        exp_q.push_back({p[b], 1'b1, 1'b1, (b == 0), 1'b0});
      end
      if ((r != 0 && n == r) || (stop_cyc > 0 && stop_cyc <= c)) begin
        fin = 1'b1;
      end else if (GAP_ON) begin
        for (int g = 0; g < GAP_LEN && !fin; g++) begin
          c++;
          exp_q.push_back(5'b00100);
          if (stop_cyc > 0 && stop_cyc <= c) fin = 1'b1;
        end
      end
    end
    exp_q.push_back(5'b00001);
  endtask

  // junk: 0 = start low while busy, 1 = random start, 2 = start held high throughout.
  task automatic run_xfer(input logic [PAT_W-1:0] p, input int r, input int stop_cyc,
                          input int junk, input string name);
    build_model(p, r, stop_cyc);
    @(posedge clk); #1;
    start = 1'b1;
    pat   = p;
    reps  = CNT_W'(r);
    stop  = 1'($urandom_range(0, 1));
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      start = (junk == 2) ? 1'b1 : (junk == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      pat   = PAT_W'($urandom);
      reps  = CNT_W'($urandom);
      stop  = (c == stop_cyc);
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[c-1]) begin
        failures++;
        $display("FAIL %s cycle %0d: out/valid/busy/frame_end/done got %b expected %b",
                 name, c, obs(), exp_q[c-1]);
      end
    end
  endtask

  task automatic idle_check(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'($urandom_range(0, 1));
      pat   = PAT_W'($urandom);
      reps  = CNT_W'($urandom);
      @(negedge clk);
      checks++;
      if (obs() !== 5'b00000) begin
        failures++;
        $display("FAIL %s idle %0d: outputs got %b expected 00000", name, c, obs());
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    pat   = 3'b101;
    reps  = 4'd1;
    #3;
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_state: outputs got %b expected 00000", obs());
    end
    #12;
    rst   = 1'b1;
    start = 1'b0;
    idle_check(2, "after_reset");
  endtask

  task automatic test_single();
    run_xfer(3'b101, 1, 0, 0, "single");
    idle_check(2, "single_tail");
  endtask

  task automatic test_multi();
    run_xfer(3'b101, 3, 0, 0, "multi");
    idle_check(1, "multi_tail");
  endtask

  task automatic test_stop();
    run_xfer(3'b110, 0, 5, 0, "stop_cont");
    idle_check(2, "stop_tail");
  endtask

  task automatic test_back_to_back();
    run_xfer(3'b101, 1, 0, 2, "busy_start");
    run_xfer(3'b011, 1, 0, 0, "restart");
    idle_check(1, "restart_tail");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    pat   = 3'b101;
    reps  = 4'd2;
    stop  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 5'b11100) begin
      failures++;
      $display("FAIL reset_mid_first_bit: got %b expected 11100", obs());
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_async: got %b expected 00000", obs());
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs() !== 5'b00000) begin
        failures++;
        $display("FAIL reset_hold: got %b expected 00000", obs());
      end
    end
    rst = 1'b1;
    idle_check(1, "post_reset_idle");
    run_xfer(3'b101, 1, 0, 0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      logic [PAT_W-1:0] p;
      int r;
      int sc;
      p = PAT_W'($urandom);
      r = (i == 0) ? (1 << CNT_W) - 1 : int'($urandom_range(0, (1 << CNT_W) - 1));
      if (r == 0) sc = int'($urandom_range(1, 20));
      else if ($urandom_range(0, 2) == 0) sc = int'($urandom_range(1, (PAT_W + GAP_LEN) * r));
      else sc = 0;
      if (i == 0) sc = 0;
      run_xfer(p, r, sc, 1, $sformatf("random%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check(1, $sformatf("random%0d_tail", i));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
